// File: rtl/mc_ctl_pkg.sv
// mc_ctl_pkg: shared definitions for the multi-cycle MIPS control unit.
//   - state_t      : 4-bit FSM state encodings (IF..JMP; 10-15 unused)
//   - OP_*         : supported opcodes (IR[31:26])
//   - ALU_*, PCS_*, SRCB_* : datapath select encodings
//   - ctl_out_t    : bundle of every control output driven per state
package mc_ctl_pkg;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_EXE  = 4'd6,
        S_RWB  = 4'd7,
        S_BR   = 4'd8,
        S_JMP  = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       MemtoReg;
        logic [1:0] PCSource;
        logic [1:0] ALUop;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic       RegWrite;
        logic       RegDst;
    } ctl_out_t;

endpackage

// File: rtl/mc_ctl_if.sv
// mc_ctl_if: control-unit bus. The master (bench/datapath side) drives run
// and OP; the slave (mc_ctl) drives every control line, state and illegal.
interface mc_ctl_if;
    logic       run;
    logic [5:0] OP;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic [1:0] PCSource;
    logic [1:0] ALUop;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic       RegDst;
    logic [3:0] state;
    logic       illegal;

    modport master (
        output run, OP,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, PCSource, ALUop, ALUSrcA, ALUSrcB, RegWrite,
               RegDst, state, illegal
    );

    modport slave (
        input  run, OP,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, PCSource, ALUop, ALUSrcA, ALUSrcB, RegWrite,
               RegDst, state, illegal
    );
endinterface

// File: rtl/mc_ctl_outdec.sv
// mc_ctl_outdec: Moore output decode. Pure combinational map from the
// current state and run to the control bundle.
//   state_i : current FSM state
//   run_i   : advance enable; 0 kills every strobe that changes architectural state
//   out_o   : control bundle
module mc_ctl_outdec
    import mc_ctl_pkg::*;
(
    input  state_t   state_i,
    input  logic     run_i,
    output ctl_out_t out_o
);

    always_comb begin
        out_o = '0;
        case (state_i)
            S_IF: begin
                out_o.MemRead = 1'b1;
                out_o.IRWrite = 1'b1;
                out_o.ALUSrcB = SRCB_FOUR;
                out_o.PCWrite = 1'b1;
            end
            S_ID:   out_o.ALUSrcB = SRCB_IMMSH2;
            S_MADR: begin
                out_o.ALUSrcA = 1'b1;
                out_o.ALUSrcB = SRCB_IMM;
            end
            S_MRD: begin
                out_o.MemRead = 1'b1;
                out_o.IorD    = 1'b1;
            end
            S_MWB: begin
                out_o.RegWrite = 1'b1;
                out_o.MemtoReg = 1'b1;
            end
            S_MWR: begin
                out_o.MemWrite = 1'b1;
                out_o.IorD     = 1'b1;
            end
            S_EXE: begin
                out_o.ALUSrcA = 1'b1;
                out_o.ALUop   = ALU_FUNCT;
            end
            S_RWB: begin
                out_o.RegWrite = 1'b1;
                out_o.RegDst   = 1'b1;
            end
            S_BR: begin
                out_o.ALUSrcA     = 1'b1;
                out_o.ALUop       = ALU_SUB;
                out_o.PCWriteCond = 1'b1;
                out_o.PCSource    = PCS_ALUOUT;
            end
            S_JMP: begin
                out_o.PCWrite  = 1'b1;
                out_o.PCSource = PCS_JUMP;
            end
            default: out_o = '0;
        endcase

        // Stalled: selects stay state-decoded so the datapath is stable,
        // but nothing may be written or read.
        if (!run_i) begin
            out_o.PCWrite     = 1'b0;
            out_o.PCWriteCond = 1'b0;
            out_o.IRWrite     = 1'b0;
            out_o.RegWrite    = 1'b0;
            out_o.MemRead     = 1'b0;
            out_o.MemWrite    = 1'b0;
        end
    end

endmodule

// File: rtl/mc_ctl.sv
// mc_ctl: multi-cycle MIPS control unit (Moore FSM).
//   clk   : clock, rising edge
//   reset : asynchronous active-high; state -> IF, illegal -> 0
//   bus   : mc_ctl_if.slave -- run/OP in, all control lines, state, illegal out
module mc_ctl
    import mc_ctl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mc_ctl_if.slave     bus
);

    state_t   state_q, state_d;
    logic     illegal_q, illegal_d;
    ctl_out_t ctl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IF;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // OP is only consulted in ID and MADR, so OP changes elsewhere are inert.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        if (bus.run) begin
            case (state_q)
                S_IF: state_d = S_ID;
                S_ID: begin
                    case (bus.OP)
                        OP_LW, OP_SW: state_d = S_MADR;
                        OP_RTYPE:     state_d = S_EXE;
                        OP_BEQ:       state_d = S_BR;
                        OP_J:         state_d = S_JMP;
                        default: begin
                            state_d   = S_IF;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                S_MADR: state_d = (bus.OP == OP_SW) ? S_MWR : S_MRD;
                S_MRD:  state_d = S_MWB;
                S_EXE:  state_d = S_RWB;
                S_MWB, S_MWR, S_RWB, S_BR, S_JMP: state_d = S_IF;
                default: state_d = S_IF;  // recover from unused encodings
            endcase
        end
    end

    mc_ctl_outdec u_outdec (
        .state_i (state_q),
        .run_i   (bus.run),
        .out_o   (ctl)
    );

    assign bus.PCWrite     = ctl.PCWrite;
    assign bus.PCWriteCond = ctl.PCWriteCond;
    assign bus.IorD        = ctl.IorD;
    assign bus.MemRead     = ctl.MemRead;
    assign bus.MemWrite    = ctl.MemWrite;
    assign bus.IRWrite     = ctl.IRWrite;
    assign bus.MemtoReg    = ctl.MemtoReg;
    assign bus.PCSource    = ctl.PCSource;
    assign bus.ALUop       = ctl.ALUop;
    assign bus.ALUSrcA     = ctl.ALUSrcA;
    assign bus.ALUSrcB     = ctl.ALUSrcB;
    assign bus.RegWrite    = ctl.RegWrite;
    assign bus.RegDst      = ctl.RegDst;
    assign bus.state       = state_q;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_mc_ctl.sv
// tb_mc_ctl: directed bench for mc_ctl. Inputs change just after falling
// edges; outputs are sampled on falling edges, away from the rising edge.
module tb_mc_ctl;
    import mc_ctl_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    mc_ctl_if bus ();

    mc_ctl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        bus.run = 1'b1;
        bus.OP  = OP_LW;
        @(negedge clk);
        @(negedge clk);

        // Reset values with run=1
        chk("rst_state",   8'(bus.state), 8'd0);
        chk("rst_illegal", 8'(bus.illegal), 8'd0);
        chk("rst_strobes", {5'd0, bus.MemRead, bus.IRWrite, bus.PCWrite}, 8'b111);
        chk("rst_srcb",    8'(bus.ALUSrcB), 8'd1);
        chk("rst_others",  {bus.PCWriteCond, bus.IorD, bus.MemWrite, bus.MemtoReg,
                            bus.RegWrite, bus.RegDst, bus.ALUSrcA, 1'b0}, 8'd0);
        // Reset values with run=0: strobes drop, select stays
        bus.run = 1'b0;
        #1;
        chk("rst_run0_strobes", {5'd0, bus.MemRead, bus.IRWrite, bus.PCWrite}, 8'd0);
        chk("rst_run0_srcb",    8'(bus.ALUSrcB), 8'd1);
        bus.run = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // lw: 0,1,2,3,4,0
        chk("lw_s0", 8'(bus.state), 8'd0);
        tick(); chk("lw_s1", 8'(bus.state), 8'd1);
        chk("lw_id_srcb", 8'(bus.ALUSrcB), 8'd3);
        chk("lw_id_memread", 8'(bus.MemRead), 8'd0);
        tick(); chk("lw_s2", 8'(bus.state), 8'd2);
        chk("lw_madr_sel", {5'd0, bus.ALUSrcA, bus.ALUSrcB}, 8'b110);
        tick(); chk("lw_s3", 8'(bus.state), 8'd3);
        chk("lw_mrd", {6'd0, bus.MemRead, bus.IorD}, 8'b11);
        chk("lw_mrd_regwr", 8'(bus.RegWrite), 8'd0);
        tick(); chk("lw_s4", 8'(bus.state), 8'd4);
        chk("lw_mwb", {6'd0, bus.RegWrite, bus.MemtoReg}, 8'b11);
        bus.OP = OP_SW;
        tick(); chk("lw_end", 8'(bus.state), 8'd0);

        // sw: 0,1,2,5,0
        tick(); chk("sw_s1", 8'(bus.state), 8'd1);
        tick(); chk("sw_s2", 8'(bus.state), 8'd2);
        chk("sw_madr_memwr", 8'(bus.MemWrite), 8'd0);
        tick(); chk("sw_s5", 8'(bus.state), 8'd5);
        chk("sw_mwr", {5'd0, bus.MemWrite, bus.IorD, bus.RegWrite}, 8'b110);
        bus.OP = OP_RTYPE;
        tick(); chk("sw_end", 8'(bus.state), 8'd0);
        chk("sw_end_memwr", 8'(bus.MemWrite), 8'd0);

        // R-type: 0,1,6,7
        tick(); chk("r_s1", 8'(bus.state), 8'd1);
        tick(); chk("r_s6", 8'(bus.state), 8'd6);
        chk("r_exe", {5'd0, bus.ALUSrcA, bus.ALUop}, 8'b110);
        tick(); chk("r_s7", 8'(bus.state), 8'd7);
        chk("r_rwb", {5'd0, bus.RegDst, bus.RegWrite, bus.MemtoReg}, 8'b110);
        bus.OP = OP_BEQ;
        // beq: 0,1,8
        tick(); chk("beq_s0", 8'(bus.state), 8'd0);
        tick(); chk("beq_s1", 8'(bus.state), 8'd1);
        tick(); chk("beq_s8", 8'(bus.state), 8'd8);
        chk("beq_ctl", {bus.PCWriteCond, bus.PCWrite, bus.ALUop, bus.PCSource, bus.ALUSrcA, 1'b0},
            8'b1_0_01_01_1_0);
        bus.OP = OP_J;
        // j: 0,1,9
        tick(); chk("j_s0", 8'(bus.state), 8'd0);
        tick(); chk("j_s1", 8'(bus.state), 8'd1);
        tick(); chk("j_s9", 8'(bus.state), 8'd9);
        chk("j_ctl", {3'd0, bus.PCWrite, bus.PCWriteCond, bus.PCSource, 1'b0}, 8'b00010100);

        // Illegal opcode: 0,1,0 and sticky flag
        bus.OP = 6'b111111;
        tick(); chk("ill_s0", 8'(bus.state), 8'd0);
        tick(); chk("ill_s1", 8'(bus.state), 8'd1);
        chk("ill_before", 8'(bus.illegal), 8'd0);
        tick(); chk("ill_s0b", 8'(bus.state), 8'd0);
        chk("ill_set", 8'(bus.illegal), 8'd1);

        // lw with a 3-cycle stall in MRD; OP wiggles in stalled MRD are inert
        bus.OP = OP_LW;
        tick(); tick();
        tick(); chk("hold_s3", 8'(bus.state), 8'd3);
        bus.run = 1'b0;
        bus.OP  = OP_SW;
        #1;
        chk("hold_memread0", 8'(bus.MemRead), 8'd0);
        chk("hold_iord", 8'(bus.IorD), 8'd1);
        tick(); chk("hold_c2", 8'(bus.state), 8'd3);
        tick(); chk("hold_c3", 8'(bus.state), 8'd3);
        chk("hold_c3_memread", 8'(bus.MemRead), 8'd0);
        bus.run = 1'b1;
        #1;
        chk("hold_release", {6'd0, bus.state == 4'd3, bus.MemRead}, 8'b11);
        tick(); chk("hold_s4", 8'(bus.state), 8'd4);
        chk("hold_mwb_regwr", 8'(bus.RegWrite), 8'd1);
        tick(); chk("hold_end", 8'(bus.state), 8'd0);
        chk("ill_sticky", 8'(bus.illegal), 8'd1);

        // sw into MWR, then asynchronous reset mid-cycle
        tick(); tick();
        tick(); chk("rst_mwr_s5", 8'(bus.state), 8'd5);
        chk("rst_mwr_memwr", 8'(bus.MemWrite), 8'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_state", 8'(bus.state), 8'd0);
        chk("rst_async_memwr", 8'(bus.MemWrite), 8'd0);
        chk("rst_async_ill", 8'(bus.illegal), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(); chk("post_rst_s1", 8'(bus.state), 8'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
